// File: rtl/sram_bus_arbiter.sv
// Arbitrates the inst and data SRAM-like masters onto one SRAM-like slave port,
// with a response-ordering FIFO. Define SRAM_ARB_RR_EN for round-robin grant.
module sram_bus_arbiter #(
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_DATA = 2'd1,
    HOLD_INST = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OUTSTANDING-1:0] fifo_q, fifo_d;

  logic gnt_inst;
  logic gnt_data;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic push_src;
  logic head_src;

`ifdef SRAM_ARB_RR_EN
  logic last_grant_q, last_grant_d;
`endif

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OUTSTANDING - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(OUTSTANDING));
  assign empty = (count_q == '0);

  // Grant FSM: IDLE grants combinationally; HOLD_* locks until address handshake.
  always_comb begin
    state_d  = state_q;
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!full) begin
`ifdef SRAM_ARB_RR_EN
          if (data_sram_req && (!inst_sram_req || last_grant_q == SRC_INST)) begin
            gnt_data = 1'b1;
          end else if (inst_sram_req) begin
            gnt_inst = 1'b1;
          end
`else
          if (data_sram_req) begin
            gnt_data = 1'b1;
          end else if (inst_sram_req) begin
            gnt_inst = 1'b1;
          end
`endif
          if (gnt_data && !mem_addr_ok) begin
            state_d = HOLD_DATA;
          end else if (gnt_inst && !mem_addr_ok) begin
            state_d = HOLD_INST;
          end
        end
      end
      HOLD_DATA: begin
        gnt_data = 1'b1;
        if (data_sram_req && mem_addr_ok) begin
          state_d = IDLE;
        end
      end
      HOLD_INST: begin
        gnt_inst = 1'b1;
        if (inst_sram_req && mem_addr_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_data) begin
      mem_req   = data_sram_req;
      mem_wr    = data_sram_wr;
      mem_size  = data_sram_size;
      mem_wstrb = data_sram_wstrb;
      mem_addr  = data_sram_addr;
      mem_wdata = data_sram_wdata;
    end else if (gnt_inst) begin
      mem_req   = inst_sram_req;
      mem_wr    = inst_sram_wr;
      mem_size  = inst_sram_size;
      mem_wstrb = inst_sram_wstrb;
      mem_addr  = inst_sram_addr;
      mem_wdata = inst_sram_wdata;
    end
  end

  assign push     = mem_req & mem_addr_ok;
  assign push_src = gnt_data ? SRC_DATA : SRC_INST;
  assign pop      = mem_data_ok & ~empty;
  assign head_src = fifo_q[rd_ptr_q];

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = push_src;
      wr_ptr_d         = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    last_grant_d = last_grant_q;
    if (push) begin
      last_grant_d = push_src;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= SRC_INST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fifo_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fifo_q   <= fifo_d;
    end
  end

  assign inst_sram_addr_ok = mem_addr_ok & gnt_inst;
  assign data_sram_addr_ok = mem_addr_ok & gnt_data;
  assign inst_sram_data_ok = pop & (head_src == SRC_INST);
  assign data_sram_data_ok = pop & (head_src == SRC_DATA);
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter (default OUTSTANDING=2); honours SRAM_ARB_RR_EN.
module tb_sram_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic        exp_q[$];

  sram_bus_arbiter #(.OUTSTANDING(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .mem_req           (mem_req),
    .mem_wr            (mem_wr),
    .mem_size          (mem_size),
    .mem_wstrb         (mem_wstrb),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_addr_ok       (mem_addr_ok),
    .mem_data_ok       (mem_data_ok),
    .mem_rdata         (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops the oldest expected source and checks routing of the current response.
  task automatic check_route(input logic [31:0] rd);
    logic src;
    if (exp_q.size() == 0) begin
      check("empty_inst_dok", 32'(inst_sram_data_ok), 32'd0);
      check("empty_data_dok", 32'(data_sram_data_ok), 32'd0);
    end else begin
      src = exp_q.pop_front();
      check("inst_dok", 32'(inst_sram_data_ok), 32'(!src));
      check("data_dok", 32'(data_sram_data_ok), 32'(src));
      check("rdata", src ? data_sram_rdata : inst_sram_rdata, rd);
    end
  endtask

  task automatic respond(input logic [31:0] rd);
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    #2;
    check_route(rd);
    tick();
    mem_data_ok = 1'b0;
  endtask

  task automatic drain();
    int unsigned k = 0;
    while (exp_q.size() > 0) begin
      respond(32'hD000_0000 + k);
      k++;
    end
  endtask

  task automatic idle_all();
    inst_sram_req = 1'b0;
    data_sram_req = 1'b0;
    mem_addr_ok   = 1'b0;
    mem_data_ok   = 1'b0;
  endtask

  initial begin
    logic exp_src;
    reset = 1'b1;
    idle_all();
    inst_sram_wr = 1'b0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'h0;
    inst_sram_addr = '0; inst_sram_wdata = '0;
    data_sram_wr = 1'b1; data_sram_size = 2'd2; data_sram_wstrb = 4'hF;
    data_sram_addr = '0; data_sram_wdata = 32'h1234_5678;
    mem_rdata = '0;

    tick();
    tick();
    mem_data_ok = 1'b1;
    #2;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_inst_aok", 32'(inst_sram_addr_ok), 32'd0);
    check("rst_data_aok", 32'(data_sram_addr_ok), 32'd0);
    check("rst_inst_dok", 32'(inst_sram_data_ok), 32'd0);
    check("rst_data_dok", 32'(data_sram_data_ok), 32'd0);
    check("rst_count", 32'(dut.count_q), 32'd0);
    tick();
    mem_data_ok = 1'b0;
    reset = 1'b0;

    // Single read
    inst_sram_req = 1'b1;
    inst_sram_addr = 32'h1C00_0000;
    mem_addr_ok = 1'b1;
    #2;
    check("rd_mem_req", 32'(mem_req), 32'd1);
    check("rd_mem_addr", mem_addr, 32'h1C00_0000);
    check("rd_inst_aok", 32'(inst_sram_addr_ok), 32'd1);
    check("rd_data_aok", 32'(data_sram_addr_ok), 32'd0);
    exp_q.push_back(1'b0);
    tick();
    idle_all();
    tick();
    respond(32'h0280_0000);

    // Contention: both masters keep requesting; responses overlap later pushes
    inst_sram_req = 1'b1;
    data_sram_req = 1'b1;
    mem_addr_ok   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_sram_addr = 32'h8000_0000 + 32'(k * 4);
      inst_sram_addr = 32'h1C00_0100 + 32'(k * 4);
      mem_data_ok    = (k > 0);
      mem_rdata      = 32'hA000_0000 + 32'(k);
`ifdef SRAM_ARB_RR_EN
      exp_src = (k % 2 == 0);
`else
      exp_src = 1'b1;
`endif
      #2;
      check("ct_mem_req", 32'(mem_req), 32'd1);
      check("ct_mem_addr", mem_addr, exp_src ? data_sram_addr : inst_sram_addr);
      check("ct_mem_wr", 32'(mem_wr), 32'(exp_src));
      check("ct_data_aok", 32'(data_sram_addr_ok), 32'(exp_src));
      check("ct_inst_aok", 32'(inst_sram_addr_ok), 32'(!exp_src));
      if (k > 0) check_route(mem_rdata);
      exp_q.push_back(exp_src);
      tick();
    end
`ifndef SRAM_ARB_RR_EN
    data_sram_req = 1'b0;
    mem_data_ok   = 1'b1;
    mem_rdata     = 32'hA000_0004;
    #2;
    check("ct_inst_late_aok", 32'(inst_sram_addr_ok), 32'd1);
    check("ct_inst_late_addr", mem_addr, 32'h1C00_010C);
    check_route(32'hA000_0004);
    exp_q.push_back(1'b0);
    tick();
`endif
    idle_all();
    drain();

    // Lock: data stalls 3 cycles while inst requests
    data_sram_req  = 1'b1;
    data_sram_addr = 32'h8000_0040;
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1C00_0200;
    mem_addr_ok    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("lk_mem_addr", mem_addr, 32'h8000_0040);
      check("lk_mem_req", 32'(mem_req), 32'd1);
      check("lk_inst_aok", 32'(inst_sram_addr_ok), 32'd0);
      tick();
    end
    mem_addr_ok = 1'b1;
    #2;
    check("lk_hs_addr", mem_addr, 32'h8000_0040);
    check("lk_hs_data_aok", 32'(data_sram_addr_ok), 32'd1);
    check("lk_hs_inst_aok", 32'(inst_sram_addr_ok), 32'd0);
    exp_q.push_back(1'b1);
    tick();
    data_sram_req = 1'b0;
    #2;
    check("lk_inst_aok", 32'(inst_sram_addr_ok), 32'd1);
    check("lk_inst_addr", mem_addr, 32'h1C00_0200);
    exp_q.push_back(1'b0);
    tick();
    idle_all();
    drain();

    // Full: two accepted, third blocked even across a same-cycle pop
    inst_sram_req = 1'b1;
    mem_addr_ok   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      inst_sram_addr = 32'h1C00_0300 + 32'(i * 4);
      #2;
      check("fl_accept", 32'(inst_sram_addr_ok), 32'd1);
      exp_q.push_back(1'b0);
      tick();
    end
    inst_sram_addr = 32'h1C00_0308;
    #2;
    check("fl_blocked_req", 32'(mem_req), 32'd0);
    check("fl_blocked_aok", 32'(inst_sram_addr_ok), 32'd0);
    check("fl_count", 32'(dut.count_q), 32'd2);
    tick();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hB000_0000;
    #2;
    check("fl_pop_req", 32'(mem_req), 32'd0);
    check_route(32'hB000_0000);
    tick();
    mem_data_ok = 1'b0;
    #2;
    check("fl_after_req", 32'(mem_req), 32'd1);
    check("fl_after_aok", 32'(inst_sram_addr_ok), 32'd1);
    exp_q.push_back(1'b0);
    tick();
    idle_all();
    drain();

    // Spurious response with empty FIFO
    respond(32'hDEAD_BEEF);
    #2;
    check("sp_count", 32'(dut.count_q), 32'd0);

    // Reset while locked in HOLD_INST with one outstanding entry
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1C00_0400;
    mem_addr_ok    = 1'b1;
    #2;
    check("rm_first_aok", 32'(inst_sram_addr_ok), 32'd1);
    exp_q.push_back(1'b0);
    tick();
    inst_sram_addr = 32'h1C00_0404;
    mem_addr_ok    = 1'b0;
    tick();
    data_sram_req  = 1'b1;
    data_sram_addr = 32'h8000_0400;
    #2;
    check("rm_hold_addr", mem_addr, 32'h1C00_0404);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hC000_0000;
    #2;
    check("rm_fresh_req", 32'(mem_req), 32'd1);
    check("rm_fresh_addr", mem_addr, 32'h8000_0400);
    check("rm_count", 32'(dut.count_q), 32'd0);
    check_route(32'hC000_0000);
    tick();
    idle_all();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
